// File: rtl/cpld_bank_cfg_ctrl.sv
// Bank-select sequencer: filters Z80 OUT writes to 0x7Fxx with data[7:6]==11 and commits them to ramblock_q.
// DEFER_COMMIT_EN selects a commit deferred to a safe point outside memory cycles; without it the commit happens when IORQ* is released.
module cpld_bank_cfg_ctrl #(
   parameter logic [5:0] RESET_BLOCK = 6'b000000
`ifdef DEFER_COMMIT_EN
   ,
   parameter int         SAFE_CYCLES = 2,
   parameter int         MAX_WAIT    = 15,
   parameter int         CNT_W       = 4
`endif
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic       iorq_b,
   input  logic       wr_b,
   input  logic       m1_b,
   input  logic       mreq_b,
   input  logic       adr15,
   input  logic [7:0] data,
   output logic [5:0] ramblock_q,
   output logic       cfg_pending,
   output logic       cfg_update
);

   typedef enum logic [1:0] {S_IDLE, S_QUAL, S_WAIT_IO, S_COMMIT} state_t;

   state_t     state_q, state_d;
   logic [5:0] ramblock_d;
   logic [5:0] pending_q, pending_d;
   logic       pend_flag_q, pend_flag_d;
   logic       cfg_update_q, cfg_update_d;
   logic       q;
   logic       capture;

   assign q       = !iorq_b && !wr_b && m1_b && !adr15;
   assign capture = (state_q == S_QUAL) && q && (data[7:6] == 2'b11);

`ifdef DEFER_COMMIT_EN
   logic [CNT_W-1:0] safe_cnt_q, safe_cnt_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             commit_go;

   assign commit_go = (mreq_b && (safe_cnt_q == CNT_W'(SAFE_CYCLES - 1))) ||
                      (wait_cnt_q == CNT_W'(MAX_WAIT));
`else
   logic unused_mreq;
   assign unused_mreq = mreq_b;
`endif

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q      <= S_IDLE;
         ramblock_q   <= RESET_BLOCK;
         pending_q    <= 6'd0;
         pend_flag_q  <= 1'b0;
         cfg_update_q <= 1'b0;
`ifdef DEFER_COMMIT_EN
         safe_cnt_q   <= '0;
         wait_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         ramblock_q   <= ramblock_d;
         pending_q    <= pending_d;
         pend_flag_q  <= pend_flag_d;
         cfg_update_q <= cfg_update_d;
`ifdef DEFER_COMMIT_EN
         safe_cnt_q   <= safe_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (q) state_d = S_QUAL;
         S_QUAL:    state_d = q ? S_WAIT_IO : S_IDLE;
         S_WAIT_IO: begin
            if (iorq_b) begin
`ifdef DEFER_COMMIT_EN
               state_d = pend_flag_q ? S_COMMIT : S_IDLE;
`else
               state_d = S_IDLE;
`endif
            end
         end
         S_COMMIT: begin
`ifdef DEFER_COMMIT_EN
            // A new write takes priority so the older pending value is abandoned.
            if (q)              state_d = S_QUAL;
            else if (commit_go) state_d = S_IDLE;
`else
            state_d = S_IDLE;
`endif
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ramblock_d   = ramblock_q;
      pending_d    = pending_q;
      pend_flag_d  = pend_flag_q;
      cfg_update_d = 1'b0;
`ifdef DEFER_COMMIT_EN
      safe_cnt_d   = '0;
      wait_cnt_d   = '0;
`endif
      if (capture) begin
         pending_d   = data[5:0];
         pend_flag_d = 1'b1;
      end
`ifdef DEFER_COMMIT_EN
      if ((state_q == S_COMMIT) && !q) begin
         if (commit_go) begin
            ramblock_d   = pending_q;
            cfg_update_d = 1'b1;
            pend_flag_d  = 1'b0;
         end else begin
            safe_cnt_d = mreq_b ? safe_cnt_q + 1'b1 : '0;
            wait_cnt_d = (wait_cnt_q == CNT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
         end
      end
`else
      if ((state_q == S_WAIT_IO) && iorq_b && pend_flag_q) begin
         ramblock_d   = pending_q;
         cfg_update_d = 1'b1;
         pend_flag_d  = 1'b0;
      end
`endif
   end

   assign cfg_pending = pend_flag_q;
   assign cfg_update  = cfg_update_q;

endmodule
